// File: rtl/am_mod_arbiter_if.sv
// Modulator-side bus of am_mod_arbiter: the two voice-path sources with
// their tuning/depth settings, and the registered drive to the AM modulator.
interface am_mod_arbiter_if #(
  parameter int INPUT_WIDTH = 12,
  parameter int PHASE_WIDTH = 32
);
  logic [1:0]             req;
  logic [PHASE_WIDTH-1:0] fre0;
  logic [PHASE_WIDTH-1:0] fre1;
  logic [15:0]            deep0;
  logic [15:0]            deep1;
  logic [INPUT_WIDTH-1:0] wave0;
  logic [INPUT_WIDTH-1:0] wave1;
  logic [1:0]             grant;
  logic                   busy;
  logic [PHASE_WIDTH-1:0] center_fre;
  logic [15:0]            module_deep;
  logic [INPUT_WIDTH-1:0] wave_out;

  // Channel sources / observer side
  modport master (
    output req, fre0, fre1, deep0, deep1, wave0, wave1,
    input  grant, busy, center_fre, module_deep, wave_out
  );

  // Arbiter side
  modport slave (
    input  req, fre0, fre1, deep0, deep1, wave0, wave1,
    output grant, busy, center_fre, module_deep, wave_out
  );
endinterface

// File: rtl/am_mod_arbiter.sv
// Round-robin time-sharing of one AM modulator between two transmit
// channels, with depth ramp-down/ramp-up around every hand-over.
// Optional macro AM_ARB_PREEMPT_EN: ch0 priority, a fresh ch0 request
// pre-empts a ch1 owner and wins the following arbitration.
module am_mod_arbiter #(
  parameter int INPUT_WIDTH = 12,
  parameter int PHASE_WIDTH = 32,
  parameter int SLOT_CYCLES = 48000,
  parameter int RAMP_STEP   = 4096
) (
  input logic              clk_in,
  input logic              RST,
  am_mod_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RAMP_UP, ACTIVE, RAMP_DOWN} state_t;

  localparam logic [23:0] SLOT_LAST = 24'(SLOT_CYCLES - 1);
  localparam logic [16:0] STEP17    = 17'(RAMP_STEP);

  state_t                 state_q, state_d;
  logic                   sel_q, sel_d;     // channel chosen by last arbitration
  logic                   last_q, last_d;   // last/current owner
  logic [15:0]            target_q, target_d;
  logic [23:0]            cnt_q, cnt_d;
  logic [1:0]             grant_q, grant_d;
  logic                   busy_q;
  logic [PHASE_WIDTH-1:0] cfre_q, cfre_d;
  logic [15:0]            md_q, md_d;
  logic [INPUT_WIDTH-1:0] wave_q, wave_d;

  logic                   arb_valid, arb_sel;
  logic                   owner_req, other_req, slot_end;
  logic [16:0]            up_sum;
  logic [15:0]            up_val, dn_val;
  logic                   preempt, force_ch0;
  logic [INPUT_WIDTH-1:0] wave_own;

`ifdef AM_ARB_PREEMPT_EN
  logic req0_q, pend_q;

  // Track ch0 request edges and remember a pre-emption until ch0 is loaded
  always_ff @(posedge clk_in) begin
    if (RST) begin
      req0_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      req0_q <= bus.req[0];
      if (preempt)
        pend_q <= 1'b1;
      else if (state_q == LOAD)
        pend_q <= 1'b0;
    end
  end

  assign preempt   = last_q && (state_q == RAMP_UP || state_q == ACTIVE) &&
                     bus.req[0] && !req0_q;
  assign force_ch0 = pend_q;
`else
  assign preempt   = 1'b0;
  assign force_ch0 = 1'b0;
`endif

  // Arbitration, ramp arithmetic and slot bookkeeping helpers
  always_comb begin
    arb_valid = |bus.req;
    arb_sel   = 1'b0;
    if (bus.req == 2'b10)
      arb_sel = 1'b1;
    else if (bus.req == 2'b11)
      arb_sel = force_ch0 ? 1'b0 : ~last_q;
    owner_req = last_q ? bus.req[1] : bus.req[0];
    other_req = last_q ? bus.req[0] : bus.req[1];
    slot_end  = (cnt_q == SLOT_LAST);
    up_sum    = {1'b0, md_q} + STEP17;
    up_val    = (up_sum > {1'b0, target_q}) ? target_q : up_sum[15:0];
    dn_val    = ({1'b0, md_q} > STEP17) ? (md_q - STEP17[15:0]) : '0;
    wave_own  = last_q ? bus.wave1 : bus.wave0;
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (arb_valid) state_d = LOAD;
      LOAD:      state_d = RAMP_UP;
      RAMP_UP: begin
        if (!owner_req || preempt) state_d = RAMP_DOWN;
        else if (up_val == target_q) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!owner_req || preempt || (slot_end && other_req))
          state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (md_q == '0) state_d = arb_valid ? LOAD : IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and per-slot context
  always_comb begin
    sel_d    = sel_q;
    last_d   = last_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    cfre_d   = cfre_q;
    md_d     = md_q;
    wave_d   = '0;
    unique case (state_q)
      IDLE: sel_d = arb_sel;
      LOAD: begin
        cfre_d   = sel_q ? bus.fre1 : bus.fre0;
        target_d = sel_q ? bus.deep1 : bus.deep0;
        grant_d  = sel_q ? 2'b10 : 2'b01;
        last_d   = sel_q;
        cnt_d    = '0;
      end
      RAMP_UP: begin
        wave_d = wave_own;
        // Leaving for RAMP_DOWN holds the current depth for one cycle
        if (state_d != RAMP_DOWN) md_d = up_val;
      end
      ACTIVE: begin
        wave_d = wave_own;
        if (state_d == RAMP_DOWN || slot_end) cnt_d = '0;
        else                                  cnt_d = cnt_q + 24'd1;
      end
      RAMP_DOWN: begin
        wave_d = wave_own;
        md_d   = dn_val;
        if (md_q == '0) begin
          grant_d = '0;
          sel_d   = arb_sel;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk_in) begin
    if (RST) begin
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      target_q <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      cfre_q   <= '0;
      md_q     <= '0;
      wave_q   <= '0;
    end else begin
      sel_q    <= sel_d;
      last_q   <= last_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      busy_q   <= (state_d != IDLE);
      cfre_q   <= cfre_d;
      md_q     <= md_d;
      wave_q   <= wave_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.busy        = busy_q;
  assign bus.center_fre  = cfre_q;
  assign bus.module_deep = md_q;
  assign bus.wave_out    = wave_q;

endmodule

// File: doc/am_mod_arbiter.md
Name: am_mod_arbiter

Overview:
- Time-shares the single AM modulator between two transmit channels (ch0, ch1) using round-robin slots.
- Drives the modulator's wave_in, module_deep and center_fre directly.
- Ramps modulation depth down before each hand-over and back up after it, so channel switches are click-free.
- Sits between the two voice-path sample sources and the modulator input.

Parameters:
- INPUT_WIDTH, 12, sample width of wave0/wave1/wave_out.
- PHASE_WIDTH, 32, width of the frequency tuning words.
- SLOT_CYCLES, 48000, clk_in cycles per grant slot; legal range 2..2^24-1.
- RAMP_STEP, 4096, module_deep change per cycle during ramps; legal range 1..65535.

Ports:
- clk_in  in  1  clock
- RST  in  1  reset; synchronous, active-high
- req  in  2  per-channel transmit request; level-sensitive
- fre0  in  PHASE_WIDTH  ch0 tuning word
- fre1  in  PHASE_WIDTH  ch1 tuning word
- deep0  in  16  ch0 target depth
- deep1  in  16  ch1 target depth
- wave0  in  INPUT_WIDTH  ch0 samples
- wave1  in  INPUT_WIDTH  ch1 samples
- grant  out  2  one-hot owner; 0 when idle
- busy  out  1  high whenever state != IDLE
- center_fre  out  PHASE_WIDTH  to modulator
- module_deep  out  16  to modulator
- wave_out  out  INPUT_WIDTH  to modulator wave_in

Behaviour:
- Reset (RST=1 at a clk_in edge): state=IDLE, grant=0, busy=0, center_fre=0, module_deep=0, wave_out=0, slot counter=0, last-owner pointer=1 (so ch0 wins first contention). Reset mid-ramp or mid-slot aborts immediately; no ramp-down is performed.
- All outputs are registered.
- Arbitration: decided in IDLE, or at the end of RAMP_DOWN.
  - Only one req bit set: that channel is selected.
  - Both set: the channel != last-owner pointer is selected.
  - Neither set: go to / stay in IDLE.
- LOAD (1 cycle):
  - center_fre <= fre[sel]; target <= deep[sel] (latched); grant <= onehot(sel); last-owner pointer <= sel; module_deep stays 0.
  - Next state: RAMP_UP.
- RAMP_UP:
  - Each cycle, module_deep <= min(module_deep + RAMP_STEP, target), computed 17-bit with no wrap.
  - Enter ACTIVE on the cycle module_deep equals target. Target 0 reaches ACTIVE after 1 cycle.
  - Owner drops req during RAMP_UP: go to RAMP_DOWN from the current depth.
- ACTIVE:
  - Slot counter increments from 0.
  - Owner drops req: go to RAMP_DOWN.
  - Counter reaches SLOT_CYCLES-1 and the other channel requests: go to RAMP_DOWN.
  - Counter reaches SLOT_CYCLES-1 and the other channel does not request: counter restarts at 0; owner retains the grant.
- RAMP_DOWN:
  - Each cycle, module_deep <= max(module_deep - RAMP_STEP, 0).
  - Cycle after module_deep reaches 0: grant <= 0, then arbitrate. Go to LOAD if any req is set, else IDLE.
  - req changes during RAMP_DOWN do not abort it.
- Sample path, latency 1: wave_out <= wave[owner] in RAMP_UP, ACTIVE and RAMP_DOWN; wave_out <= 0 in IDLE and LOAD.
- Config latching: fre/deep changes while a channel owns the grant are ignored until that channel's next LOAD. center_fre holds its last value in IDLE.
- Invariants:
  - grant is never two-hot.
  - module_deep is nonzero only while grant != 0.
  - Ownership never changes unless module_deep == 0.

Optional Feature:
- AM_ARB_PREEMPT_EN defined: ch0 has priority. If ch1 owns (RAMP_UP or ACTIVE) and req[0] rises, go to RAMP_DOWN immediately regardless of the slot counter. The next arbitration selects ch0 even if ch0 was the last owner.
- Not defined: pure round-robin slots as described above; ch0 has no priority.

Test Plan:
- RST, then req=01, deep0=0xFFFF, RAMP_STEP=4096 -> LOAD 1 cycle; module_deep 4096, 8192 ... 61440, then 65535 on the 16th RAMP_UP cycle; grant=01; wave_out tracks wave0 with 1 cycle delay.
- SLOT_CYCLES=64, req=11 held -> ch0 ACTIVE 64 cycles, ramp down to 0, grant=00 for 1 cycle, LOAD ch1 with center_fre=fre1. Alternation repeats.
- SLOT_CYCLES=64, req=01 held for 200 cycles -> slot counter wraps 3 times; grant stays 01; module_deep stays at target.
- req[0] dropped mid-RAMP_UP at module_deep=12288 -> ramp down 8192, 4096, 0; grant=00; busy=0 one cycle later.
- RST asserted during ACTIVE with module_deep=0xFFFF -> next cycle all outputs 0, IDLE; the following contention picks ch0.
- With AM_ARB_PREEMPT_EN: ch1 ACTIVE, req[0] rises at slot count 5 -> RAMP_DOWN next cycle, then LOAD ch0. Without the macro -> ch1 keeps the grant until count 63.
